// File: rtl/maze_pkg.sv
// Shared types and default sizing for the maze run sequencer.
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RSTS,
        SOLVE,
        CHECK,
        DUMP
    } state_t;

    localparam int DEF_SIZE    = 15;
    localparam int DEF_TIMEOUT = 20000;

endpackage

// File: rtl/maze_path_check.sv
// Combinational legality check of a solver path against the loaded maze.
module maze_path_check
    import maze_pkg::*;
#(
    parameter int SIZE = DEF_SIZE
) (
    input  logic [SIZE*SIZE-1:0] maze,
    input  logic [SIZE*SIZE-1:0] path,
    output logic                 path_wrong,
    output logic                 start_ok,
    output logic                 end_ok
);

    // A legal path never crosses a wall and exactly fills the openings of the edge rows.
    assign path_wrong = |(path & maze);
    assign start_ok   = (path[0 +: SIZE] == ~maze[0 +: SIZE]);
    assign end_ok     = (path[(SIZE-1)*SIZE +: SIZE] == ~maze[(SIZE-1)*SIZE +: SIZE]);

endmodule

// File: rtl/maze_run_ctrl.sv
// Run sequencer: loads a maze, resets and times the solver, checks the path and streams it out.
module maze_run_ctrl
    import maze_pkg::*;
#(
    parameter int SIZE       = DEF_SIZE,
    parameter int N          = $clog2(SIZE),
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int CW         = 32,
    parameter int RST_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [SIZE-1:0]      row_data,
    output logic [SIZE*SIZE-1:0] maze_flat,
    output logic                 solver_rst,
    input  logic                 solver_done,
    input  logic [SIZE*SIZE-1:0] path_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE-1:0]      out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 run_done,
    output logic                 timeout,
    output logic                 path_wrong,
    output logic                 start_ok,
    output logic                 end_ok,
    output logic [CW-1:0]        solve_cycles
);

    localparam int            RW   = $clog2(RST_CYCLES + 1);
    localparam logic [N-1:0]  LAST = N'(SIZE - 1);

    state_t                 state;
    logic [N-1:0]           idx;
    logic [CW-1:0]          cnt;
    logic [RW-1:0]          rcnt;
    logic [SIZE*SIZE-1:0]   path_snap;
    logic                   chk_wrong;
    logic                   chk_start;
    logic                   chk_end;

    maze_path_check #(.SIZE(SIZE)) u_check (
        .maze       (maze_flat),
        .path       (path_flat),
        .path_wrong (chk_wrong),
        .start_ok   (chk_start),
        .end_ok     (chk_end)
    );

    // Handshake and status outputs are pure decodes of the state register.
    assign busy       = (state != IDLE);
    assign row_ready  = (state == LOAD);
    assign solver_rst = (state == IDLE) || (state == LOAD) || (state == RSTS);
    assign out_valid  = (state == DUMP);
    assign out_data   = out_valid ? path_snap[idx*SIZE +: SIZE] : '0;
    assign out_last   = out_valid && (idx == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            cnt          <= '0;
            rcnt         <= '0;
            maze_flat    <= '1;
            path_snap    <= '0;
            timeout      <= 1'b0;
            path_wrong   <= 1'b0;
            start_ok     <= 1'b0;
            end_ok       <= 1'b0;
            solve_cycles <= '0;
            run_done     <= 1'b0;
        end else begin
            run_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        timeout      <= 1'b0;
                        path_wrong   <= 1'b0;
                        start_ok     <= 1'b0;
                        end_ok       <= 1'b0;
                        solve_cycles <= '0;
                        idx          <= '0;
                        state        <= LOAD;
                    end
                end
                LOAD: begin
                    if (row_valid) begin
                        maze_flat[idx*SIZE +: SIZE] <= row_data;
                        if (idx == LAST) begin
                            rcnt  <= '0;
                            cnt   <= '0;
                            state <= RSTS;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                RSTS: begin
                    if (rcnt == RW'(RST_CYCLES - 1)) begin
                        cnt   <= CW'(1);
                        state <= SOLVE;
                    end else begin
                        rcnt <= rcnt + 1'b1;
                    end
                end
                SOLVE: begin
                    // A done arriving on the timeout cycle still counts as a solve.
                    if (solver_done) begin
                        solve_cycles <= cnt;
                        state        <= CHECK;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        timeout      <= 1'b1;
                        solve_cycles <= CW'(TIMEOUT);
                        state        <= CHECK;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CHECK: begin
                    path_snap  <= path_flat;
                    path_wrong <= chk_wrong;
                    start_ok   <= chk_start;
                    end_ok     <= chk_end;
                    idx        <= '0;
                    state      <= DUMP;
                end
                DUMP: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            run_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_run_ctrl.sv
// Randomized bench for maze_run_ctrl with a behavioural reference model checked every cycle.
module tb_maze_run_ctrl;

    localparam int SIZE    = 5;
    localparam int N       = 3;
    localparam int TIMEOUT = 100;
    localparam int CW      = 32;
    localparam int RSTC    = 2;
    localparam int SS      = SIZE * SIZE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic row_valid = 1'b0;
    logic solver_done = 1'b0;
    logic out_ready = 1'b0;
    logic [SIZE-1:0] row_data = '0;
    logic [SS-1:0]   path_flat = '0;

    logic            row_ready, solver_rst, out_valid, out_last, busy, run_done;
    logic            timeout, path_wrong, start_ok, end_ok;
    logic [SS-1:0]   maze_flat;
    logic [SIZE-1:0] out_data;
    logic [CW-1:0]   solve_cycles;

    maze_run_ctrl #(.SIZE(SIZE), .N(N), .TIMEOUT(TIMEOUT), .CW(CW), .RST_CYCLES(RSTC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .row_valid(row_valid), .row_ready(row_ready),
        .row_data(row_data), .maze_flat(maze_flat), .solver_rst(solver_rst), .solver_done(solver_done),
        .path_flat(path_flat), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .run_done(run_done), .timeout(timeout),
        .path_wrong(path_wrong), .start_ok(start_ok), .end_ok(end_ok), .solve_cycles(solve_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Test vectors: row r of each packed array is row r of the maze/path.
    logic [SIZE-1:0][SIZE-1:0] tm, tp;

    // Reference model (phase: 0 idle, 1 loading, 2 solver reset, 3 solving, 4 checking, 5 dumping).
    int              m_ph = 0, m_idx = 0, m_dump = 0, m_rleft = 0, m_cnt = 0;
    logic [SIZE-1:0] m_maze [SIZE];
    logic [SIZE-1:0] m_snap [SIZE];
    logic            m_to = 0, m_pw = 0, m_so = 0, m_eo = 0, m_rd = 0;
    longint          m_sc = 0;
    logic [SS-1:0]   mf;
    logic [SIZE-1:0] e_od;

    logic [SIZE-1:0] beats[$];
    logic            lasts[$];
    int              rd_cnt = 0, rsts_cyc = 0;

    function automatic void model_reset();
        m_ph = 0; m_idx = 0; m_dump = 0; m_rleft = 0; m_cnt = 0;
        m_to = 0; m_pw = 0; m_so = 0; m_eo = 0; m_rd = 0; m_sc = 0;
        for (int r = 0; r < SIZE; r++) begin
            m_maze[r] = '1;
            m_snap[r] = '0;
        end
    endfunction

    function automatic void model_step();
        m_rd = 0;
        case (m_ph)
            0: if (start) begin
                m_ph = 1; m_idx = 0; m_to = 0; m_pw = 0; m_so = 0; m_eo = 0; m_sc = 0;
            end
            1: if (row_valid) begin
                m_maze[m_idx] = row_data;
                if (m_idx == SIZE - 1) begin m_ph = 2; m_rleft = RSTC; end
                else m_idx++;
            end
            2: begin
                m_rleft--;
                if (m_rleft == 0) begin m_ph = 3; m_cnt = 1; end
            end
            3: if (solver_done) begin m_sc = m_cnt; m_ph = 4; end
               else if (m_cnt == TIMEOUT) begin m_to = 1; m_sc = TIMEOUT; m_ph = 4; end
               else m_cnt++;
            4: begin
                m_pw = 0;
                for (int r = 0; r < SIZE; r++) begin
                    m_snap[r] = path_flat[r*SIZE +: SIZE];
                    for (int c = 0; c < SIZE; c++)
                        if (path_flat[r*SIZE + c] && m_maze[r][c]) m_pw = 1;
                end
                m_so = (m_snap[0] == ~m_maze[0]);
                m_eo = (m_snap[SIZE-1] == ~m_maze[SIZE-1]);
                m_dump = 0;
                m_ph = 5;
            end
            5: if (out_ready) begin
                if (m_dump == SIZE - 1) begin m_rd = 1; m_ph = 0; end
                else m_dump++;
            end
            default: m_ph = 0;
        endcase
    endfunction

    // Compare process: check every output mid-cycle, then advance the model on the same inputs.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        for (int r = 0; r < SIZE; r++) mf[r*SIZE +: SIZE] = m_maze[r];
        e_od = (m_ph == 5) ? m_snap[m_dump] : '0;
        chk("busy", busy, m_ph != 0);
        chk("row_ready", row_ready, m_ph == 1);
        chk("solver_rst", solver_rst, m_ph <= 2);
        chk("out_valid", out_valid, m_ph == 5);
        chk("out_data", out_data, e_od);
        chk("out_last", out_last, (m_ph == 5) && (m_dump == SIZE - 1));
        chk("run_done", run_done, m_rd);
        chk("timeout", timeout, m_to);
        chk("path_wrong", path_wrong, m_pw);
        chk("start_ok", start_ok, m_so);
        chk("end_ok", end_ok, m_eo);
        chk("solve_cycles", solve_cycles, m_sc);
        chk("maze_flat", maze_flat, mf);
        if (out_valid && out_ready) begin
            beats.push_back(out_data);
            lasts.push_back(out_last);
        end
        if (run_done) rd_cnt++;
        if (busy && solver_rst && !row_ready) rsts_cyc++;
        if (rst_n) model_step();
    end

    // Stub solver: raises done on its done_at-th cycle out of reset (0 = never).
    int done_at = 0, sc = 0;
    always @(posedge clk) begin
        #1;
        if (solver_rst) sc = 0;
        else sc++;
        solver_done = (done_at != 0) && (sc == done_at);
    end

    // out_ready source: 0 always ready, 1 fixed 1,0,0,1,0,1 pattern, 2 random.
    int rmode = 0, pidx = 0;
    int pat [6] = '{1, 0, 0, 1, 0, 1};
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 1'b1;
            1: begin out_ready = pat[pidx % 6] != 0; pidx++; end
            default: out_ready = ($urandom % 2) == 1;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rows(input int mode, input bit start_mid);
        int r = 0, t = 0, g = 0;
        logic acc;
        while (r < SIZE && g < 200) begin
            row_valid = (mode == 0) ? (t % 2 == 0) : (($urandom % 2) == 1);
            row_data  = row_valid ? tm[r] : SIZE'($urandom);
            start     = start_mid && (r == 2);
            @(negedge clk);
            acc = row_valid && row_ready;
            tick();
            if (acc) r++;
            t++; g++;
        end
        row_valid = 1'b0;
        start = 1'b0;
        if (r < SIZE) chk("load_bound", 0, 1);
    endtask

    task automatic run(input int mode, input int dat, input int rm, input bit start_mid);
        int g = 0, b0, rd0, rs0;
        rmode = rm; pidx = 0; done_at = dat; path_flat = tp;
        b0 = beats.size(); rd0 = rd_cnt; rs0 = rsts_cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_rows(mode, start_mid);
        while (busy && g < TIMEOUT + 300) begin tick(); g++; end
        if (busy) chk("run_bound", 0, 1);
        tick(); tick();
        chk("beat_count", beats.size() - b0, SIZE);
        for (int i = 0; i < SIZE && b0 + i < beats.size(); i++) begin
            chk("beat_row", beats[b0+i], tp[i]);
            chk("beat_last", lasts[b0+i], i == SIZE - 1);
        end
        chk("run_done_pulses", rd_cnt - rd0, 1);
        chk("rsts_cycles", rsts_cyc - rs0, RSTC);
        chk("maze_loaded", maze_flat, tm);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, rd0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_maze_all_ones", maze_flat, {SS{1'b1}});
        chk("rst_solver_rst", solver_rst, 1);
        chk("rst_busy", busy, 0);

        // Legal straight corridor down column 2; solver finishes on cycle 37.
        tm[0] = 5'b11011; tm[1] = 5'b10001; tm[2] = 5'b10001; tm[3] = 5'b10001; tm[4] = 5'b11011;
        for (int r = 0; r < SIZE; r++) tp[r] = 5'b00100;
        run(0, 37, 0, 0);
        chk("legal_solve_cycles", solve_cycles, 37);
        chk("legal_path_wrong", path_wrong, 0);
        chk("legal_start_ok", start_ok, 1);
        chk("legal_end_ok", end_ok, 1);
        chk("legal_timeout", timeout, 0);

        // Solver never finishes.
        run(1, 0, 2, 0);
        chk("to_timeout", timeout, 1);
        chk("to_solve_cycles", solve_cycles, 100);

        // Wall at (2,2) under the path, bad exit row, stalled output.
        tm[2] = 5'b10101;
        tp[4] = 5'b00110;
        run(1, 20, 1, 0);
        chk("wall_path_wrong", path_wrong, 1);
        chk("wall_start_ok", start_ok, 1);
        chk("wall_end_ok", end_ok, 0);
        chk("wall_solve_cycles", solve_cycles, 20);

        // Done on the same cycle the counter reaches the limit.
        tp[4] = 5'b00100;
        run(1, TIMEOUT, 2, 0);
        chk("tie_timeout", timeout, 0);
        chk("tie_solve_cycles", solve_cycles, 100);

        // Asynchronous abort in the middle of a solve.
        done_at = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        load_rows(1, 0);
        g = 0;
        while (solver_rst && g < 50) begin tick(); g++; end
        chk("abort_reached_solve", solver_rst, 0);
        repeat (5) tick();
        rd0 = rd_cnt;
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_solver_rst", solver_rst, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_maze", maze_flat, {SS{1'b1}});
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) tick();
        chk("abort_no_run_done", rd_cnt - rd0, 0);

        // Start held during loading must not disturb the run.
        for (int r = 0; r < SIZE; r++) begin
            tm[r] = SIZE'($urandom);
            tp[r] = ~tm[r];
        end
        run(1, 15, 0, 1);
        chk("midstart_start_ok", start_ok, 1);
        chk("midstart_solve_cycles", solve_cycles, 15);

        for (int k = 0; k < 8; k++) begin
            for (int r = 0; r < SIZE; r++) begin
                tm[r] = SIZE'($urandom);
                tp[r] = (($urandom % 2) == 1) ? ~tm[r] : SIZE'($urandom);
            end
            run(1, $urandom_range(130, 1), 2, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_run_ctrl.md
Name: maze_run_ctrl

Overview:
- Run sequencer for the mazeEscaper solver.
- Accepts a maze row-by-row over a valid/ready stream and holds it in a register array that drives the solver's maze input.
- Holds the solver in reset while loading, releases it, and counts solve cycles against a timeout.
- After the solve, checks the path for legality, then streams the path rows out with valid/ready plus status. This replaces the testbench-only load/check flow with synthesizable control.

Parameters:
- SIZE, 15: maze side length; odd so there are walls on both sides.
- N, $clog2(SIZE): row index width.
- TIMEOUT, 20000: SOLVE cycles allowed before giving up.
- CW, 32: width of the cycle counter.
- RST_CYCLES, 2: cycles solver_rst is held high before SOLVE.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle run request; honoured only in IDLE.
- row_valid  in  1  maze row valid.
- row_ready  out  1  maze row ready.
- row_data  in  SIZE  maze row; 1 = wall.
- maze_flat  out  SIZE*SIZE  maze to the solver; row r at [r*SIZE +: SIZE].
- solver_rst  out  1  active-high reset to the solver.
- solver_done  in  1  solver done.
- path_flat  in  SIZE*SIZE  solver path, same layout as maze_flat.
- out_valid  out  1  path row valid.
- out_ready  in  1  path row ready.
- out_data  out  SIZE  path row.
- out_last  out  1  high with row SIZE-1.
- busy  out  1  high whenever state is not IDLE.
- run_done  out  1  one-cycle pulse when a run completes.
- timeout  out  1  sticky; cleared by start.
- path_wrong  out  1  sticky; cleared by start.
- start_ok  out  1  sticky; cleared by start.
- end_ok  out  1  sticky; cleared by start.
- solve_cycles  out  CW  captured solve length.

Behaviour:
- Reset (async on rst_n low):
  - state=IDLE; maze_flat all 1s; solver_rst=1; row index 0; counter 0.
  - All other outputs 0.
  - rst_n low mid-operation aborts immediately; no run_done is issued.
- IDLE:
  - solver_rst=1, row_ready=0.
  - start=1: clear timeout, path_wrong, start_ok, end_ok and solve_cycles; row index=0; go to LOAD.
- LOAD:
  - row_ready=1.
  - On row_valid&row_ready: write row_data to maze row[idx], idx++.
  - After accepting row SIZE-1, row_ready drops next cycle and state goes to RSTS.
  - start is ignored in every non-IDLE state.
- RSTS:
  - solver_rst=1 for exactly RST_CYCLES cycles; then go to SOLVE.
  - Counter is cleared on entry.
  - solver_done is ignored here.
- SOLVE:
  - solver_rst=0; counter=1 in the first SOLVE cycle, +1 each cycle after.
  - solver_done=1 sampled: solve_cycles=counter; go to CHECK.
  - If counter==TIMEOUT and solver_done=0: timeout=1, solve_cycles=TIMEOUT, go to CHECK.
  - done and the timeout cycle coinciding: done wins, timeout stays 0.
- CHECK (one cycle):
  - Snapshot path_flat into a local path array.
  - path_wrong = OR over all bits of (path & maze).
  - start_ok = (path row0 == ~maze row0).
  - end_ok = (path row SIZE-1 == ~maze row SIZE-1).
  - Go to DUMP with idx=0.
- DUMP:
  - out_valid=1, out_data = snapshot row[idx], out_last = (idx==SIZE-1).
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - On handshake: idx++. After the last row: run_done=1 for one cycle, go to IDLE, solver_rst=1 again.
  - solver_rst stays 0 through DUMP.
- Retention: maze_flat and status persist in IDLE until the next start.
- Widths: idx is N bits, compared against SIZE-1, so it never wraps. The counter saturates at 2^CW-1.

Decomposition:
- Package maze_pkg:
  - state enum typedef: IDLE, LOAD, RSTS, SOLVE, CHECK, DUMP.
  - Default SIZE and TIMEOUT constants.
- Sub-module maze_path_check: combinational; inputs maze and path arrays; outputs path_wrong, start_ok, end_ok. Registered by the controller in CHECK.

Test Plan:
- SIZE=5, load 5 rows with row_valid low every other cycle -> maze_flat equals rows; row_ready low after the 5th accept; solver_rst high exactly 2 cycles, then low.
- Stub solver raises done on SOLVE cycle 37 with a legal path -> solve_cycles=37; path_wrong=0, start_ok=1, end_ok=1; 5 out beats, out_last on the 5th; run_done pulses once.
- TIMEOUT=100, stub never done -> timeout=1, solve_cycles=100; 5 rows still dumped.
- Stub path sets bit (2,2) where maze has a wall -> path_wrong=1; other flags reflect rows 0 and 4.
- out_ready pattern 1,0,0,1,0,1... -> out_data stable while stalled; exactly 5 beats, in order, no duplicates.
- rst_n low mid-SOLVE -> same cycle: busy=0, solver_rst=1, out_valid=0. Then start pulsed during LOAD -> no effect on index or status.
